// File: rtl/io_port_pkg.sv
// io_port_pkg: register offsets, STATUS CHG bit index and default window base for io_port
package io_port_pkg;
  localparam logic [31:0] IO_BASE_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [3:0] IO_LED_OFS = 4'h0;
  localparam logic [3:0] IO_SW_OFS = 4'h4;
  localparam logic [3:0] IO_STATUS_OFS = 4'h8;
  localparam logic [3:0] IO_IEN_OFS = 4'hC;
  localparam int IO_CHG_BIT = 0;
endpackage

// File: rtl/sw_debouncer.sv
// sw_debouncer: 2-flop sync + candidate/counter debounce; ports clk, reset, d_i (async in), stab_o (accepted value), changed_o (1-cycle pulse on the edge stab_o changes)
module sw_debouncer #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] stab_o,
  output logic         changed_o
);
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] CMAX = CW'(D - 1);
  logic [W-1:0] s1_q, s2_q, cand_q, stab_q;
  logic [CW-1:0] cnt_q;
  logic hold, done;
  assign hold = s2_q == cand_q;
  assign done = hold && cnt_q >= CMAX;
  assign changed_o = done && cand_q != stab_q;
  assign stab_o = stab_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      stab_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      if (!hold) begin
        cand_q <= s2_q;
        cnt_q <= '0;
      end else if (!done) cnt_q <= cnt_q + 1'b1;
      else stab_q <= cand_q;
    end
  end
endmodule

// File: rtl/io_port.sv
// io_port: switch/LED MMIO peripheral (LED, SW, STATUS.CHG w1c, IEN under IO_PORT_IRQ_EN); ports clk, reset, addr, wdata, we, re, rdata, sel, sw, leds_out, irq
module io_port
  import io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic [7:0]  sw,
  output logic [7:0]  leds_out,
  output logic        irq
);
  logic [7:0] led_q, led_d, stab;
  logic chg_q, chg_d, changed, wr, ien_rd, unused;
  logic [3:0] ofs;
  logic [31:0] reg_val;
  sw_debouncer #(.W(8), .D(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .reset(reset),
    .d_i(sw),
    .stab_o(stab),
    .changed_o(changed)
  );
  assign ofs = {addr[3:2], 2'b00};
  assign sel = addr[31:4] == BASE_ADDR[31:4];
  assign wr = we && sel;
  assign led_d = (wr && ofs == IO_LED_OFS) ? wdata[7:0] : led_q;
  // a new debounced value landing beats a coincident write-1-to-clear
  assign chg_d = changed | (chg_q & ~(wr && ofs == IO_STATUS_OFS && wdata[IO_CHG_BIT]));
  assign unused = ^{wdata[31:8], addr[1:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
      chg_q <= 1'b0;
    end else begin
      led_q <= led_d;
      chg_q <= chg_d;
    end
  end
`ifdef IO_PORT_IRQ_EN
  logic ien_q, ien_d;
  assign ien_d = (wr && ofs == IO_IEN_OFS) ? wdata[0] : ien_q;
  always_ff @(posedge clk) begin
    if (reset) ien_q <= 1'b0;
    else ien_q <= ien_d;
  end
  assign ien_rd = ien_q;
  assign irq = chg_q & ien_q;
`else
  assign ien_rd = 1'b0;
  assign irq = 1'b0;
`endif
  always_comb begin
    reg_val = ofs == IO_LED_OFS ? {24'b0, led_q} :
              ofs == IO_SW_OFS ? {24'b0, stab} :
              ofs == IO_STATUS_OFS ? (32'(chg_q) << IO_CHG_BIT) : {31'b0, ien_rd};
    rdata = (re && sel) ? reg_val : 32'b0;
  end
  assign leds_out = led_q;
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: self-checking bench for io_port with a sample-history debounce model and directed vectors
module tb_io_port;
  localparam int D = 4;
  logic clk = 0, reset = 1, we = 0, re = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [7:0] sw = 8'd99, leds_out;
  logic sel, irq;
  int checks = 0, failures = 0;
  io_port dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .sel(sel), .sw(sw), .leds_out(leds_out), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  int yq[$];
  logic [7:0] stab_m = 0, led_m = 0;
  logic chg_m = 0, ien_m = 0;
  bit started = 0;
  // a switch value is accepted once the synchronised stream (sw delayed by two
  // edges, forced to 0 across reset) has shown it D+1 times in a row
  always @(posedge clk) begin
    bit set, eq, hit;
    int n;
    logic [1:0] rs;
    started = 1;
    if (reset) begin
      led_m = 0; chg_m = 0; ien_m = 0; stab_m = 0;
      yq.delete(); yq.push_back(0); yq.push_back(0);
    end else begin
      hit = addr[31:4] == 28'h0000100;
      rs = addr[3:2];
      set = 0;
      n = yq.size();
      if (n >= D + 2) begin
        eq = 1;
        for (int i = n - 2 - D; i <= n - 2; i++) if (yq[i] != yq[n-2]) eq = 0;
        if (eq && yq[n-2] != int'(stab_m)) begin
          stab_m = 8'(yq[n-2]);
          set = 1;
        end
      end
      yq.push_back(int'(sw));
      if (yq.size() > 16) void'(yq.pop_front());
      if (we && hit && rs == 0) led_m = wdata[7:0];
      chg_m = set | (chg_m & !(we && hit && rs == 2 && wdata[0]));
`ifdef IO_PORT_IRQ_EN
      if (we && hit && rs == 3) ien_m = wdata[0];
`endif
    end
  end
  always @(negedge clk) if (started) begin
    bit hit;
    logic [31:0] rv;
    hit = addr[31:4] == 28'h0000100;
    case (addr[3:2])
      2'd0: rv = {24'b0, led_m};
      2'd1: rv = {24'b0, stab_m};
      2'd2: rv = {31'b0, chg_m};
      default: rv = {31'b0, ien_m};
    endcase
    chk("m_leds", {24'b0, leds_out}, {24'b0, led_m});
    chk("m_sel", {31'b0, sel}, {31'b0, hit});
    chk("m_rdata", rdata, (re && hit) ? rv : 32'b0);
    chk("m_irq", {31'b0, irq}, {31'b0, chg_m & ien_m});
  end
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    #1 addr = a; wdata = d; we = 1; re = 0;
    @(negedge clk);
    #1 we = 0;
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    #1 addr = a; re = 1;
    #1 chk(name, rdata, exp);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_leds", {24'b0, leds_out}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    #1 reset = 0; addr = 32'h1004; re = 1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("deb_sw_e%0d", k), rdata, k < 7 ? 32'h0 : 32'd99);
    end
    rd("deb_status", 32'h1008, 32'h1);
    #1 addr = 32'h1000; wdata = 32'h0000_00A5; we = 1; re = 1;
    #1 chk("led_same_cycle_old", rdata, 32'h0);
    @(negedge clk);
    chk("led_out", {24'b0, leds_out}, 32'hA5);
    chk("led_rd", rdata, 32'h0000_00A5);
    chk("led_sel", {31'b0, sel}, 32'h1);
    #1 we = 0;
    wr(32'h1008, 32'h1);
    rd("clr_status", 32'h1008, 32'h0);
    #1 sw = 8'd0;
    repeat (2) @(negedge clk);
    #1 sw = 8'd99;
    repeat (10) @(negedge clk);
    rd("bounce_sw", 32'h1004, 32'd99);
    rd("bounce_chg", 32'h1008, 32'h0);
    #1 sw = 8'd55;
    repeat (8) @(negedge clk);
    rd("chg_55", 32'h1008, 32'h1);
    #1 sw = 8'd77;
    repeat (6) @(negedge clk);
    #1 addr = 32'h1008; wdata = 32'h1; we = 1; re = 1;
    @(negedge clk);
    chk("w1c_collide", rdata, 32'h1);
    #1 we = 0;
    rd("collide_sw", 32'h1004, 32'd77);
    wr(32'h1008, 32'h1);
    rd("w1c_clear", 32'h1008, 32'h0);
    wr(32'h100C, 32'h1);
    #1 sw = 8'd12;
    repeat (6) @(negedge clk);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    @(negedge clk);
`ifdef IO_PORT_IRQ_EN
    rd("ien_rd", 32'h100C, 32'h1);
    chk("irq_hi", {31'b0, irq}, 32'h1);
`else
    rd("ien_rd", 32'h100C, 32'h0);
    chk("irq_lo", {31'b0, irq}, 32'h0);
`endif
    wr(32'h1008, 32'h1);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    #1 addr = 32'h2000; wdata = 32'hFF; we = 1; re = 1;
    @(negedge clk);
    chk("miss_leds", {24'b0, leds_out}, 32'hA5);
    chk("miss_sel", {31'b0, sel}, 32'h0);
    chk("miss_rdata", rdata, 32'h0);
    #1 reset = 1; addr = 32'h1000; wdata = 32'h3C; we = 1;
    @(negedge clk);
    chk("rst_we_leds", {24'b0, leds_out}, 32'h0);
    #1 reset = 0; we = 0; addr = 32'h1004;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("requal_e%0d", k), rdata, k < 7 ? 32'h0 : 32'd12);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
